// File: rtl/serial_tdm_pkg.sv
// serial_tdm_pkg: FSM state types, default parameters and width helper for serial_tdm_port.
package serial_tdm_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_HOLD} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SHIFT} tx_state_t;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_MSB_FIRST = 0;
  function automatic int chan_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serial_shifter.sv
// serial_shifter: loadable shift register; serial in at one end, serial out is the head bit of q.
// Ports: clk, rst (async high), en (global enable), load/din (parallel load, wins over shift),
//        shift/sin (one-bit shift with sin entering the tail), q (parallel contents).
module serial_shifter #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en) q <= load ? din : shift ? (MSB_FIRST ? {q[WIDTH-2:0], sin} : {sin, q[WIDTH-1:1]}) : q;
endmodule

// File: rtl/serial_tdm_port.sv
// serial_tdm_port: independent TDM serial receiver (serial->word, channel tagged) and transmitter (word->serial).
// Ports: i_clk, i_rst (async high), i_en (freezes everything when low);
//        RX: i_din/i_din_valid in, o_ready, o_word/o_chan/o_word_valid out with i_word_ready handshake;
//        TX: i_word/i_word_valid in with o_word_ready, o_dout/o_dout_valid out paced by i_ready;
//        o_err pulses one cycle when a receive word is cut short.
module serial_tdm_port
  import serial_tdm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_en,
  input  logic                           i_din,
  input  logic                           i_din_valid,
  output logic                           o_ready,
  output logic [DATA_WIDTH-1:0]          o_word,
  output logic [chan_w(CHANNELS)-1:0]    o_chan,
  output logic                           o_word_valid,
  input  logic                           i_word_ready,
  input  logic [DATA_WIDTH-1:0]          i_word,
  input  logic                           i_word_valid,
  output logic                           o_word_ready,
  output logic                           o_dout,
  output logic                           o_dout_valid,
  input  logic                           i_ready,
  output logic                           o_err
);
  localparam int CW = chan_w(CHANNELS);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;
  logic [CNT_W-1:0] rx_cnt, tx_cnt;
  logic [CW-1:0] chan;
  logic [DATA_WIDTH-1:0] tx_q;
  logic rx_shift, rx_last, rx_abort, rx_release;
  logic tx_load, tx_go, tx_step, tx_last;
  assign o_ready = rx_state == RX_IDLE;
  assign o_word_valid = rx_state == RX_HOLD;
  assign o_chan = chan;
  // The first bit is sampled on the same edge that leaves RX_IDLE, so shifting runs in both IDLE and SHIFT.
  assign rx_shift = i_en & i_din_valid & (rx_state != RX_HOLD);
  assign rx_last = rx_cnt == CNT_W'(DATA_WIDTH - 1);
  assign rx_abort = i_en & ~i_din_valid & (rx_state == RX_SHIFT);
  assign rx_release = i_en & i_word_ready & (rx_state == RX_HOLD);
  assign o_word_ready = tx_state == TX_IDLE;
  assign o_dout_valid = tx_state != TX_IDLE;
  assign o_dout = (tx_state == TX_SHIFT) & (MSB_FIRST != 0 ? tx_q[DATA_WIDTH-1] : tx_q[0]);
  assign tx_load = i_en & i_word_valid & (tx_state == TX_IDLE);
  assign tx_go = i_en & i_ready & (tx_state == TX_WAIT);
  assign tx_step = i_en & (tx_state == TX_SHIFT);
  assign tx_last = tx_cnt == CNT_W'(DATA_WIDTH - 1);
  always_comb begin
    rx_next = rx_state;
    tx_next = tx_state;
    rx_next = rx_state == RX_IDLE ? (rx_shift ? RX_SHIFT : RX_IDLE)
            : rx_state == RX_SHIFT ? (rx_abort ? RX_IDLE : (rx_shift && rx_last) ? RX_HOLD : RX_SHIFT)
            : rx_release ? RX_IDLE : RX_HOLD;
    tx_next = tx_state == TX_IDLE ? (tx_load ? TX_WAIT : TX_IDLE)
            : tx_state == TX_WAIT ? (tx_go ? TX_SHIFT : TX_WAIT)
            : (tx_step && tx_last) ? TX_IDLE : TX_SHIFT;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
    end else if (i_en) begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      rx_cnt <= '0;
      tx_cnt <= '0;
      chan <= '0;
      o_err <= 1'b0;
    end else begin
      o_err <= rx_abort;
      if (i_en) begin
        rx_cnt <= (rx_shift && !rx_last) ? rx_cnt + 1'b1 : '0;
        tx_cnt <= (tx_step && !tx_last) ? tx_cnt + 1'b1 : '0;
        if (rx_release) chan <= chan == CW'(CHANNELS - 1) ? '0 : chan + 1'b1;
      end
    end
  serial_shifter #(.WIDTH(DATA_WIDTH), .MSB_FIRST(MSB_FIRST != 0)) u_rx (
    .clk(i_clk), .rst(i_rst), .en(i_en), .load(1'b0), .din('0),
    .shift(rx_shift), .sin(i_din), .q(o_word)
  );
  serial_shifter #(.WIDTH(DATA_WIDTH), .MSB_FIRST(MSB_FIRST != 0)) u_tx (
    .clk(i_clk), .rst(i_rst), .en(i_en), .load(tx_load), .din(i_word),
    .shift(tx_step), .sin(1'b0), .q(tx_q)
  );
endmodule

// File: tb/tb_serial_tdm_port.sv
// tb_serial_tdm_port: scoreboard bench driving an LSB-first and an MSB-first port with shared stimulus.
module tb_serial_tdm_port;
  localparam int W = 24;
  typedef struct { logic [W-1:0] w0; logic [W-1:0] w1; int ch; } rx_exp_t;
  logic i_clk = 0, i_rst = 1, i_en = 1, i_din = 0, i_din_valid = 0;
  logic i_word_ready = 0, i_word_valid = 0, i_ready = 0;
  logic [W-1:0] i_word = '0;
  logic o_ready_m[2], o_word_valid_m[2], o_word_ready_m[2], o_dout_m[2], o_dout_valid_m[2], o_err_m[2];
  logic [W-1:0] o_word_m[2];
  logic [0:0] o_chan_m[2];
  int n_tests = 0, n_fail = 0, n_rx = 0, n_abort = 0;
  int err_seen[2] = '{0, 0};
  int tx_phase = 0, tx_k = 0;
  bit en_mode = 0;
  int wr_mode = 2;
  rx_exp_t rx_q[$];
  logic [W-1:0] tx_q[$];
  logic [W-1:0] got[2];
  serial_tdm_port #(.DATA_WIDTH(W), .CHANNELS(2), .MSB_FIRST(0)) u_lsb (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_din(i_din), .i_din_valid(i_din_valid),
    .o_ready(o_ready_m[0]), .o_word(o_word_m[0]), .o_chan(o_chan_m[0]), .o_word_valid(o_word_valid_m[0]),
    .i_word_ready(i_word_ready), .i_word(i_word), .i_word_valid(i_word_valid), .o_word_ready(o_word_ready_m[0]),
    .o_dout(o_dout_m[0]), .o_dout_valid(o_dout_valid_m[0]), .i_ready(i_ready), .o_err(o_err_m[0])
  );
  serial_tdm_port #(.DATA_WIDTH(W), .CHANNELS(2), .MSB_FIRST(1)) u_msb (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_din(i_din), .i_din_valid(i_din_valid),
    .o_ready(o_ready_m[1]), .o_word(o_word_m[1]), .o_chan(o_chan_m[1]), .o_word_valid(o_word_valid_m[1]),
    .i_word_ready(i_word_ready), .i_word(i_word), .i_word_valid(i_word_valid), .o_word_ready(o_word_ready_m[1]),
    .o_dout(o_dout_m[1]), .o_dout_valid(o_dout_valid_m[1]), .i_ready(i_ready), .o_err(o_err_m[1])
  );
  initial forever #5 i_clk = ~i_clk;
  initial forever begin
    @(posedge i_clk);
    #1;
    i_en = en_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial forever begin
    @(posedge i_clk);
    #1;
    i_word_ready = wr_mode == 1 ? 1'b0 : wr_mode == 2 ? 1'b1 : 1'($urandom_range(0, 1));
  end
  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge i_clk) begin
    if (i_rst) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("rst_word[%0d]", d), o_word_m[d], 0);
        check($sformatf("rst_chan[%0d]", d), o_chan_m[d], 0);
        check($sformatf("rst_word_valid[%0d]", d), o_word_valid_m[d], 0);
        check($sformatf("rst_dout[%0d]", d), o_dout_m[d], 0);
        check($sformatf("rst_dout_valid[%0d]", d), o_dout_valid_m[d], 0);
        check($sformatf("rst_err[%0d]", d), o_err_m[d], 0);
        check($sformatf("rst_ready[%0d]", d), o_ready_m[d], 1);
        check($sformatf("rst_word_ready[%0d]", d), o_word_ready_m[d], 1);
      end
      rx_q.delete();
      tx_q.delete();
      tx_phase = 0;
      tx_k = 0;
    end else begin
      for (int d = 0; d < 2; d++) if (o_err_m[d]) err_seen[d]++;
      if (i_en && i_word_ready && (o_word_valid_m[0] || o_word_valid_m[1])) begin
        check("rx_expected_word", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          rx_exp_t e;
          e = rx_q.pop_front();
          for (int d = 0; d < 2; d++) begin
            check($sformatf("rx_valid[%0d]", d), o_word_valid_m[d], 1);
            check($sformatf("rx_word[%0d]", d), o_word_m[d], d == 0 ? e.w0 : e.w1);
            check($sformatf("rx_chan[%0d]", d), o_chan_m[d], e.ch);
          end
        end
      end
      for (int d = 0; d < 2; d++) begin
        check($sformatf("tx_dout_valid[%0d]", d), o_dout_valid_m[d], tx_phase != 0);
        check($sformatf("tx_word_ready[%0d]", d), o_word_ready_m[d], tx_phase == 0);
        if (tx_phase != 2) check($sformatf("tx_dout_idle[%0d]", d), o_dout_m[d], 0);
      end
      if (tx_phase == 2) begin
        if (i_en) begin
          got[0][tx_k] = o_dout_m[0];
          got[1][W-1-tx_k] = o_dout_m[1];
          tx_k++;
          if (tx_k == W) begin
            check("tx_expected_word", tx_q.size() != 0, 1);
            if (tx_q.size() != 0) begin
              logic [W-1:0] w;
              w = tx_q.pop_front();
              check("tx_serial[0]", got[0], w);
              check("tx_serial[1]", got[1], w);
            end
            tx_phase = 0;
          end
        end
      end else if (tx_phase == 1) begin
        if (i_en && i_ready) begin
          tx_phase = 2;
          tx_k = 0;
        end
      end else if (i_en && i_word_valid) tx_phase = 1;
    end
  end
  task automatic en_edge();
    bit took;
    int g;
    g = 0;
    do begin
      @(posedge i_clk);
      took = i_en;
      #1;
      g++;
    end while (!took && g < 1000);
  endtask
  task automatic send_rx(input logic [W-1:0] w, input int abort_at);
    int g;
    g = 0;
    while (!o_ready_m[0] && g < 300) begin
      @(posedge i_clk);
      #1;
      g++;
    end
    check("rx_ready_wait", o_ready_m[0], 1);
    for (int k = 0; k < W; k++) begin
      i_din = w[k];
      i_din_valid = k != abort_at;
      en_edge();
      if (k == abort_at) break;
    end
    i_din_valid = 0;
    i_din = 0;
    if (abort_at >= 0) begin
      n_abort++;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("abort_err_hi[%0d]", d), o_err_m[d], 1);
        check($sformatf("abort_no_word[%0d]", d), o_word_valid_m[d], 0);
      end
      @(posedge i_clk);
      #1;
      for (int d = 0; d < 2; d++) check($sformatf("abort_err_lo[%0d]", d), o_err_m[d], 0);
    end else begin
      rx_q.push_back('{w, rev(w), n_rx % 2});
      n_rx++;
      for (int d = 0; d < 2; d++) check($sformatf("rx_valid_after_last[%0d]", d), o_word_valid_m[d], 1);
    end
  endtask
  task automatic send_tx(input logic [W-1:0] w, input int delay);
    int g;
    g = 0;
    i_ready = 0;
    while (!o_word_ready_m[0] && g < 300) begin
      @(posedge i_clk);
      #1;
      g++;
    end
    check("tx_ready_wait", o_word_ready_m[0], 1);
    i_word = w;
    i_word_valid = 1;
    en_edge();
    i_word_valid = 0;
    tx_q.push_back(w);
    repeat (delay) begin
      @(posedge i_clk);
      #1;
    end
    i_ready = 1;
    g = 0;
    while (!o_word_ready_m[0] && g < 300) begin
      @(posedge i_clk);
      #1;
      g++;
    end
    check("tx_done_wait", o_word_ready_m[0], 1);
    i_ready = 0;
  endtask
  task automatic do_reset();
    i_din_valid = 0;
    i_word_valid = 0;
    i_ready = 0;
    i_rst = 1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 0;
    n_rx = 0;
  endtask
  initial begin
    logic [W-1:0] a;
    int g;
    do_reset();
    en_mode = 0;
    wr_mode = 2;
    send_rx(24'h123456, -1);
    check("s1_word", o_word_m[0], 24'h123456);
    check("s1_chan", o_chan_m[0], 0);
    check("s2_word", o_word_m[1], 24'h6A2C48);
    repeat (3) @(posedge i_clk);
    #1;
    do_reset();
    send_rx(W'($urandom), 10);
    send_rx(24'hC0FFEE, -1);
    check("s3_chan", o_chan_m[0], 0);
    repeat (3) @(posedge i_clk);
    #1;
    do_reset();
    wr_mode = 1;
    a = W'($urandom);
    send_rx(a, -1);
    repeat (8) begin
      @(posedge i_clk);
      #1;
      check("s4_ready_low", o_ready_m[0], 0);
      check("s4_word_stable", o_word_m[0], a);
      check("s4_valid_held", o_word_valid_m[0], 1);
    end
    wr_mode = 2;
    send_rx(W'($urandom), -1);
    check("s4_chan_b", o_chan_m[0], 1);
    send_rx(W'($urandom), -1);
    check("s4_chan_c", o_chan_m[0], 0);
    send_tx(24'hABCDEF, 5);
    en_mode = 1;
    wr_mode = 0;
    fork
      repeat (12) send_rx(W'($urandom), ($urandom % 4 == 0) ? int'($urandom_range(1, 22)) : -1);
      repeat (10) send_tx(W'($urandom), int'($urandom_range(0, 6)));
    join
    i_word = W'($urandom);
    i_word_valid = 1;
    en_edge();
    i_word_valid = 0;
    tx_q.push_back(i_word);
    i_ready = 1;
    g = 0;
    while (!(tx_phase == 2 && tx_k >= 12) && g < 500) begin
      @(posedge i_clk);
      #1;
      g++;
    end
    check("s6_reached_bit12", tx_k >= 12, 1);
    do_reset();
    send_tx(W'($urandom), 2);
    send_rx(W'($urandom), -1);
    en_mode = 0;
    wr_mode = 2;
    repeat (60) @(posedge i_clk);
    #1;
    check("rx_queue_drained", rx_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    check("err_count[0]", err_seen[0], n_abort);
    check("err_count[1]", err_seen[1], n_abort);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_tdm_port.md
SERIAL_TDM_PORT -- requirements
Module: serial_tdm_port

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 24, meaning bits per sample word (range 8..32).
REQ-003 The block SHALL take parameter CHANNELS, default 2, meaning TDM channels per frame (range 1..16).
REQ-004 The block SHALL take parameter MSB_FIRST, default 0, meaning the serial bit order (0 = LSB first, 1 = MSB first), applied to both directions.
REQ-005 The port list SHALL be, in order:
- i_clk  in  1  clock
- i_rst  in  1  async active-high reset
- i_en  in  1  global enable; low freezes all state and counters
- i_din  in  1  serial receive data
- i_din_valid  in  1  serial receive word framing
- o_ready  out  1  receiver can accept a new word
- o_word  out  DATA_WIDTH  deserialised word
- o_chan  out  clog2(CHANNELS), min 1  channel tag of o_word
- o_word_valid  out  1  o_word/o_chan valid
- i_word_ready  in  1  parallel consumer accepts o_word
- i_word  in  DATA_WIDTH  parallel word to transmit
- i_word_valid  in  1  i_word valid
- o_word_ready  out  1  transmitter accepts i_word
- o_dout  out  1  serial transmit data
- o_dout_valid  out  1  transmit word pending or shifting
- i_ready  in  1  serial consumer ready
- o_err  out  1  one-cycle abort pulse

Function
REQ-006 The receiver FSM SHALL have states RX_IDLE, RX_SHIFT and RX_HOLD, and o_ready SHALL equal (state == RX_IDLE).
REQ-007 The receiver SHALL leave RX_IDLE for RX_SHIFT on an edge with i_en & i_din_valid & o_ready, and SHALL sample bit 0 of the stream on that edge.
REQ-008 In RX_SHIFT, the receiver SHALL sample one bit per i_en edge; after DATA_WIDTH bits it SHALL load o_word, assert o_word_valid from the next cycle, and enter RX_HOLD.
REQ-009 Stream bit k SHALL map to word bit k when MSB_FIRST=0 and to word bit DATA_WIDTH-1-k when MSB_FIRST=1.
REQ-010 If i_din_valid is low on an RX_SHIFT edge, the receiver SHALL discard the partial word, pulse o_err for one cycle, and return to RX_IDLE; the channel counter SHALL NOT advance.
REQ-011 In RX_HOLD, an edge with i_word_ready high SHALL clear o_word_valid, advance the channel counter (wrapping from CHANNELS-1 to 0), and return the receiver to RX_IDLE.
REQ-012 o_chan SHALL equal the channel counter value at word completion; o_word and o_chan SHALL be stable while o_word_valid is high.
REQ-013 The transmitter FSM SHALL have states TX_IDLE, TX_WAIT and TX_SHIFT, and o_word_ready SHALL equal (state == TX_IDLE).
REQ-014 An edge with i_word_valid & o_word_ready SHALL capture i_word and move the transmitter to TX_WAIT; o_dout_valid SHALL be high in TX_WAIT and TX_SHIFT.
REQ-015 In TX_WAIT, an edge with i_ready high SHALL move the transmitter to TX_SHIFT, and serial bit 0 SHALL appear on o_dout in the following cycle.
REQ-016 In TX_SHIFT, o_dout SHALL present serial bit k in cycle k, independent of i_ready; o_dout_valid SHALL fall after bit DATA_WIDTH-1, and the transmitter SHALL return to TX_IDLE.
REQ-017 o_dout SHALL be 0 outside TX_SHIFT.
REQ-018 While i_en is low, both FSMs, the bit counters and the channel counter SHALL hold their values, and o_err SHALL stay low.
REQ-019 The receiver and transmitter SHALL operate fully concurrently, with no shared state.

Reset
REQ-020 Reset SHALL force RX_IDLE and TX_IDLE, clear all counters, and drive o_word, o_chan, o_word_valid, o_dout, o_dout_valid and o_err to 0; o_ready and o_word_ready SHALL be 1 after reset.
REQ-021 Reset asserted mid-word SHALL discard any partial or pending word without raising o_err.

Structure
REQ-022 Package serial_tdm_pkg SHALL hold the rx_state_t and tx_state_t enums and the default parameter constants.
REQ-023 The generic sub-module serial_shifter (parameters WIDTH and MSB_FIRST, with parallel load, serial shift in/out and enable) SHALL be instantiated once for RX and once for TX.

Verification
REQ-024 Bench parameters SHALL be DATA_WIDTH=24 and CHANNELS=2.
REQ-025 Scenario 1: MSB_FIRST=0, serial input of 0x123456 LSB-first -> o_word=0x123456, o_chan=0, o_word_valid high starting the cycle after bit 23.
REQ-026 Scenario 2: MSB_FIRST=1, same bit sequence as scenario 1 -> o_word=0x6A2C48.
REQ-027 Scenario 3: i_din_valid dropped after 10 bits -> o_err high for exactly 1 cycle, no o_word_valid; the next full word is tagged o_chan=0.
REQ-028 Scenario 4: i_word_ready held low after word A -> o_ready stays 0 and o_word=A is stable; after release, word B is tagged o_chan=1, then word C wraps to o_chan=0.
REQ-029 Scenario 5: i_word=0xABCDEF, i_ready raised 5 cycles after capture -> o_dout carries 0xABCDEF LSB-first over 24 consecutive cycles, then o_dout_valid falls and o_word_ready returns to 1.
REQ-030 Scenario 6: i_rst pulsed at bit 12 of a transmit with i_en toggling -> all outputs match their reset values, o_err=0, and the next word transfers correctly.
